// File: rtl/axi_7seg_scan.sv
// Time-multiplexed 7-segment scanner fed from the axi_7seg register bank; shadows adopt new values only at frame boundaries.
// Optional brightness PWM is enabled by defining AXI_7SEG_BRIGHTNESS_EN.
module axi_7seg_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   digit_dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [3:0]              brightness,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [6:0] SEG_INV = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_INV  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_INV = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  endfunction

  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] data_sh_q;
  logic [NUM_DIGITS-1:0]   dp_sh_q, en_sh_q;
  logic [6:0]              seg_q, seg_d;
  logic                    seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    upd_ack_q, frame_start_q;
  logic                    latch_s, gate_s, active_s;

`ifdef AXI_7SEG_BRIGHTNESS_EN
  logic [3:0] pwm_q, bright_sh_q;

  // Free-running PWM phase and brightness shadow.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pwm_q       <= 4'd0;
      bright_sh_q <= 4'd0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
      if (latch_s) begin
        bright_sh_q <= brightness;
      end else begin
        bright_sh_q <= bright_sh_q;
      end
    end
  end
`else
  logic unused_brightness_s;
  assign unused_brightness_s = ^brightness;
`endif

  // Scan position advance, latch decision and next output image.
  always_comb begin
    pcnt_d   = pcnt_q;
    idx_d    = idx_q;
    an_d     = '0;
    seg_d    = 7'h00;
    seg_dp_d = 1'b0;
    if (pcnt_q == PCNT_MAX) begin
      pcnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end
    latch_s = (pcnt_q == PCNT_MAX) && (idx_q == IDX_MAX) && upd_req;
`ifdef AXI_7SEG_BRIGHTNESS_EN
    gate_s = (pwm_q < bright_sh_q);
`else
    gate_s = 1'b1;
`endif
    active_s = (pcnt_q >= BLANK_END) && en_sh_q[idx_q] && gate_s;
    if (active_s) begin
      an_d[idx_q] = 1'b1;
      seg_d       = hex7(data_sh_q[{idx_q, 2'b00} +: 4]);
      seg_dp_d    = dp_sh_q[idx_q];
    end else begin
      an_d     = '0;
      seg_d    = 7'h00;
      seg_dp_d = 1'b0;
    end
  end

  // Counters, shadows and polarity-adjusted output registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pcnt_q        <= '0;
      idx_q         <= '0;
      data_sh_q     <= '0;
      dp_sh_q       <= '0;
      en_sh_q       <= '0;
      upd_ack_q     <= 1'b0;
      frame_start_q <= 1'b0;
      an_q          <= AN_INV;
      seg_q         <= SEG_INV;
      seg_dp_q      <= DP_INV;
    end else begin
      pcnt_q        <= pcnt_d;
      idx_q         <= idx_d;
      upd_ack_q     <= latch_s;
      frame_start_q <= (pcnt_q == '0) && (idx_q == '0);
      if (latch_s) begin
        data_sh_q <= digit_data;
        dp_sh_q   <= digit_dp;
        en_sh_q   <= digit_en;
      end else begin
        data_sh_q <= data_sh_q;
        dp_sh_q   <= dp_sh_q;
        en_sh_q   <= en_sh_q;
      end
      an_q     <= an_d ^ AN_INV;
      seg_q    <= seg_d ^ SEG_INV;
      seg_dp_q <= seg_dp_d ^ DP_INV;
    end
  end

  assign upd_ack     = upd_ack_q;
  assign frame_start = frame_start_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign seg_dp      = seg_dp_q;

endmodule

// File: tb/tb_axi_7seg_scan.sv
// Directed bench for axi_7seg_scan: 4 digits, 8-cycle slots, 2 blank cycles, active-low pins.
module tb_axi_7seg_scan;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] digit_data;
  logic [3:0]  digit_dp;
  logic [3:0]  digit_en;
  logic [3:0]  brightness;
  logic        upd_req;
  logic        upd_ack;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  an;
  logic        frame_start;

  always #5 ACLK = ~ACLK;

  axi_7seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .digit_data(digit_data), .digit_dp(digit_dp),
    .digit_en(digit_en), .brightness(brightness), .upd_req(upd_req), .upd_ack(upd_ack),
    .seg(seg), .seg_dp(seg_dp), .an(an), .frame_start(frame_start)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int fr       = 0;
  logic [3:0] pw_st   = 4'd0;
  logic [3:0] prev_pw = 4'd0;
  logic [3:0] exp_br  = 4'd0;

  // Active-low segment images for 16'h3210 and 16'hFEDC, digit 0 in bits [6:0].
  localparam logic [27:0] SEGS_3210 = {7'h30, 7'h24, 7'h79, 7'h40};
  localparam logic [27:0] SEGS_FEDC = {7'h0E, 7'h06, 7'h21, 7'h46};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic gate_open(input logic [3:0] pw, input logic [3:0] br);
`ifdef AXI_7SEG_BRIGHTNESS_EN
    return pw < br;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    @(posedge ACLK);
    prev_pw = pw_st;
    pw_st   = ARESET ? 4'd0 : pw_st + 4'd1;
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, " an"}, 32'(an), 32'hF);
    check_val({tag, " seg"}, 32'(seg), 32'h7F);
    check_val({tag, " dp"}, 32'(seg_dp), 32'h1);
    check_val({tag, " ack"}, 32'(upd_ack), 32'h0);
    check_val({tag, " fs"}, 32'(frame_start), 32'h0);
  endtask

  // One full frame; p counts output cycles, p=0 being the first blanking cycle of slot 0.
  task automatic check_frame(input logic [3:0] en, input logic [3:0] dp, input logic [27:0] segs,
                             input bit ack_exp, input int on_p, input int off_p, input int poke_p);
    for (int p = 0; p < ND * SD; p++) begin
      int slot;
      int pc;
      logic act;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic e_dp;
      step();
      slot  = p / SD;
      pc    = p % SD;
      act   = (pc >= BC) && en[slot] && gate_open(prev_pw, exp_br);
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (act) begin
        e_an[slot] = 1'b0;
        e_seg      = segs[slot*7 +: 7];
        e_dp       = ~dp[slot];
      end
      check_val($sformatf("an f%0d p%0d", fr, p), 32'(an), 32'(e_an));
      check_val($sformatf("seg f%0d p%0d", fr, p), 32'(seg), 32'(e_seg));
      check_val($sformatf("dp f%0d p%0d", fr, p), 32'(seg_dp), 32'(e_dp));
      check_val($sformatf("fs f%0d p%0d", fr, p), 32'(frame_start), 32'(p == 0));
      check_val($sformatf("ack f%0d p%0d", fr, p), 32'(upd_ack), 32'(ack_exp && (p == ND*SD-1)));
      if (ack_exp && (p == ND*SD-1)) exp_br = brightness;
      if (p == on_p) upd_req = 1'b1;
      if (p == off_p) upd_req = 1'b0;
      if (p == poke_p) digit_data = 16'hFEDC;
    end
    fr++;
  endtask

  initial begin
    ARESET     = 1'b1;
    upd_req    = 1'b0;
    digit_data = 16'h3210;
    digit_en   = 4'hF;
    digit_dp   = 4'b0100;
    brightness = 4'd15;

    for (int i = 0; i < 3; i++) begin
      step();
      check_idle($sformatf("reset%0d", i));
    end

    upd_req = 1'b1;
    ARESET  = 1'b0;
    fr      = 1;
    // Frame 1 shows zeroed shadows; the held request latches at its end.
    check_frame(4'h0, 4'h0, SEGS_3210, 1'b1, -1, ND*SD-1, -1);
    check_frame(4'hF, 4'b0100, SEGS_3210, 1'b0, -1, -1, -1);

    // Disabled digit 2: live enable changes are invisible until the next latch.
    digit_en = 4'b1011;
    check_frame(4'hF, 4'b0100, SEGS_3210, 1'b1, 0, ND*SD-1, -1);
    check_frame(4'b1011, 4'b0100, SEGS_3210, 1'b0, -1, -1, -1);

    // Mid-frame data change without a request must not reach the display.
    check_frame(4'b1011, 4'b0100, SEGS_3210, 1'b0, -1, -1, 12);
    check_frame(4'b1011, 4'b0100, SEGS_3210, 1'b0, -1, -1, -1);
    check_frame(4'b1011, 4'b0100, SEGS_3210, 1'b0, -1, -1, -1);

    // Request raised and dropped inside the frame is cancelled.
    check_frame(4'b1011, 4'b0100, SEGS_3210, 1'b0, 5, 20, -1);
    check_frame(4'b1011, 4'b0100, SEGS_3210, 1'b0, -1, -1, -1);

    // Real update to FEDC with brightness 4 (gated only when the PWM is built in).
    brightness = 4'd4;
    check_frame(4'b1011, 4'b0100, SEGS_3210, 1'b1, 0, ND*SD-1, -1);
    check_frame(4'b1011, 4'b0100, SEGS_FEDC, 1'b0, -1, -1, -1);

    // Reset mid-slot with a request pending.
    upd_req = 1'b1;
    for (int i = 0; i < 13; i++) step();
    ARESET = 1'b1;
    step();
    check_idle("midreset");
    ARESET  = 1'b0;
    upd_req = 1'b0;
    exp_br  = 4'd0;
    check_frame(4'h0, 4'h0, SEGS_3210, 1'b0, -1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_7seg_scan.md
# axi_7seg_scan

Time-multiplexed 7-segment display scanner sitting directly downstream of the axi_7seg AXI4-Lite register bank. It takes the per-digit nibble, decimal-point and enable values held in the register bank and drives the physical segment and anode pins. Digits are scanned one at a time with programmable dwell time, inter-digit blanking and optional brightness PWM. New register contents are adopted only at frame boundaries, through a req/ack handshake, so the display never shows a torn frame.

## Interface
- NUM_DIGITS, 8: number of multiplexed digits (2..16).
- SCAN_DIV, 100000: clock cycles per digit slot (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes inactive (anti-ghosting).
- ACTIVE_LOW, 1: 1 = segment and anode pins are active-low (common anode with PNP drivers); 0 = active-high.

Ports:
- ACLK  in  1  clock; everything is synchronous to it.
- ARESET  in  1  synchronous, active-high reset.
- digit_data  in  4*NUM_DIGITS  hex nibble per digit; digit i is [4i+3:4i].
- digit_dp  in  NUM_DIGITS  decimal point per digit (1 = lit).
- digit_en  in  NUM_DIGITS  digit enable (0 = digit dark, slot still consumed).
- brightness  in  4  PWM duty, in sixteenths.
- upd_req  in  1  level request to adopt the current inputs; held until upd_ack.
- upd_ack  out  1  one-cycle pulse: inputs were latched into the shadow registers.
- seg  out  7  segments, seg[0]=a … seg[6]=g.
- seg_dp  out  1  decimal point segment.
- an  out  NUM_DIGITS  digit anodes, an[i] = digit i.
- frame_start  out  1  one-cycle pulse when slot 0 begins.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and then wraps.
- At the terminal count, digit index `idx` advances and wraps from NUM_DIGITS-1 to 0.
- `frame_start` pulses on the cycle `idx` becomes 0.
- Shadow registers hold data, dp, en and brightness. The display always uses the shadow values, never the live inputs.
- Frame boundary is `idx`=NUM_DIGITS-1 and `pcnt`=SCAN_DIV-1:
  - If `upd_req`=1 on that cycle, the shadows load from the inputs and `upd_ack` pulses on the next cycle.
  - If `upd_req` is low at the boundary, nothing is latched. Dropping the request early is legal and simply cancels it.
- Hex decode (gfedcba, active-high): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Anode `an[idx]` is active only when all three hold:
  - `pcnt` >= BLANK_CYCLES;
  - the shadow enable bit for `idx` is 1;
  - the PWM gate is open.
- All other anodes are always inactive.
- Segments show the decode of the current digit whenever its anode is active; otherwise all segments are inactive.
- ACTIVE_LOW=1 inverts every `seg`, `seg_dp` and `an` bit at the output register.

## Timing
- `seg`, `seg_dp` and `an` are registered: they reflect `idx` and `pcnt` from the previous cycle (1-cycle latency).
- `frame_start` and `upd_ack` are registered pulses, exactly 1 cycle wide.
- Effect of a request:
  - Worst-case latency from `upd_req` rising to `upd_ack` is NUM_DIGITS*SCAN_DIV+1 cycles.
  - New values are displayed starting with slot 0 of the next frame.
- Reset values, applied on the clock edge with `ARESET`=1:
  - `pcnt`=0, `idx`=0, all shadows 0, `upd_ack`=0, `frame_start`=0;
  - `an`, `seg` and `seg_dp` all inactive (all 1 when ACTIVE_LOW=1).
- After reset is released, the first `frame_start` is on the first cycle with `ARESET`=0.
- Reset asserted mid-frame or mid-handshake aborts immediately. A pending `upd_req` must be re-evaluated at the next frame boundary.
- `upd_req` and `frame_start` coinciding in the same cycle needs no special handling: latching depends only on the boundary cycle.

## Configuration
- `AXI_7SEG_BRIGHTNESS_EN` defined:
  - A 4-bit free-running counter `pwm` increments every cycle.
  - The PWM gate is open while `pwm` < shadow brightness. Brightness 0 = dark; 15 = 15/16 duty.
  - The shadow brightness register is implemented.
- Not defined:
  - No PWM counter and no brightness shadow register; the gate is always open.
  - The `brightness` port exists but is ignored.

## Test plan
Parameters NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1, unless a line says otherwise.
- Reset: hold `ARESET` 3 cycles -> `an`=4'hF, `seg`=7'h7F, `seg_dp`=1, `upd_ack`=0 throughout. `frame_start` pulses on the first cycle after release, then every 32 cycles.
- Update and scan:
  - Stimulus: `digit_data`=16'h3210, `digit_en`=4'hF, `digit_dp`=4'b0100, `brightness`=15 (macro off), `upd_req` held high.
  - Required: `upd_ack` pulses once, at the end of the first frame.
  - Next frame, each slot: 2 cycles `an`=F, then 6 cycles `an[i]`=0. `seg` is ~3F, ~06, ~5B, ~4F for digits 0..3; `seg_dp`=0 only in slot 2.
- Disabled digit: `digit_en`=4'b1011 -> `an[2]` stays 1 for the whole of slot 2. Slot 3 starts at the same cycle as when all digits are enabled.
- No tearing: change `digit_data` mid-frame with `upd_req`=0 -> the output is unchanged for at least 3 frames.
- Cancelled request: raise `upd_req` and drop it before the boundary -> no `upd_ack`, shadows unchanged.
- Brightness and reset (macro on):
  - `brightness`=4, SCAN_DIV=64 -> the active anode is low for exactly 4 of every 16 cycles outside blanking.
  - Assert `ARESET` mid-slot -> the next cycle returns to the reset values.
